// File: rtl/encoder_distance_counter.sv
// Quadrature encoder front end: synchronises and deglitches the A/B pins,
// decodes quadrature steps and accumulates ticks into whole centimetres.
// Pin pair is handled as ab = {a, b}; forward order is 00->01->11->10->00.
module encoder_distance_counter #(
  parameter int TICKS_PER_CM = 12,
  parameter int FILTER_LEN   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        encoder_reset,
  output logic [31:0] encoderincm,
  output logic [31:0] enc_ticks,
  output logic        tick_pulse,
  output logic        tick_dir,
  output logic [7:0]  err_count
);

  // Arm window covers the synchroniser plus the filter so that levels present
  // at reset or at clear are absorbed instead of counted. Needs 5 bits since
  // SYNC_STAGES + FILTER_LEN can reach 17.
  localparam logic [4:0] ARM_LOAD  = 5'(SYNC_STAGES + FILTER_LEN);
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [7:0] FRAC_MAX  = 8'(TICKS_PER_CM - 1);

  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      filt;
  logic [1:0]      filt_next;
  logic [1:0][3:0] fcnt;
  logic [1:0][3:0] fcnt_next;
  logic [1:0]      prev_ab;
  logic [4:0]      arm;
  logic [7:0]      frac;
  logic            step_fwd;
  logic            step_rev;
  logic            step_bad;

  // Two-flop synchroniser for both channels.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
    end
  end

  // Per-channel stability filter: follow the synced level only after it has
  // differed from the filtered level for FILTER_LEN consecutive cycles.
  always_comb begin
    filt_next = filt;
    fcnt_next = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] != filt[i]) begin
        if (fcnt[i] == FILT_LAST) begin
          filt_next[i] = sync2[i];
        end else begin
          fcnt_next[i] = fcnt[i] + 4'd1;
        end
      end
    end
  end

  // Filter state registers; untouched by the distance clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      filt <= 2'b00;
      fcnt <= '0;
    end else begin
      filt <= filt_next;
      fcnt <= fcnt_next;
    end
  end

  // Quadrature decode of the previous versus current filtered pair.
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_bad = 1'b0;
    case ({prev_ab, filt})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_rev = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
      default: ;
    endcase
  end

  // Arming, accumulation and error counting. While arming (or clearing),
  // prev_ab tracks the value filt is taking on this edge so that a filtered
  // change landing on the last arming edge is absorbed rather than decoded.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      arm         <= ARM_LOAD;
      prev_ab     <= 2'b00;
      frac        <= 8'd0;
      encoderincm <= 32'd0;
      enc_ticks   <= 32'd0;
      tick_pulse  <= 1'b0;
      tick_dir    <= 1'b0;
      err_count   <= 8'd0;
    end else if (encoder_reset) begin
      arm         <= ARM_LOAD;
      prev_ab     <= filt_next;
      frac        <= 8'd0;
      encoderincm <= 32'd0;
      enc_ticks   <= 32'd0;
      tick_pulse  <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      tick_pulse <= 1'b0;
      if (arm != 5'd0) begin
        arm     <= arm - 5'd1;
        prev_ab <= filt_next;
      end else begin
        prev_ab <= filt;
        if (step_fwd) begin
          tick_pulse <= 1'b1;
          tick_dir   <= 1'b1;
          enc_ticks  <= enc_ticks + 32'd1;
          if (frac == FRAC_MAX) begin
            frac        <= 8'd0;
            encoderincm <= encoderincm + 32'd1;
          end else begin
            frac <= frac + 8'd1;
          end
        end else if (step_rev) begin
          tick_pulse <= 1'b1;
          tick_dir   <= 1'b0;
          enc_ticks  <= enc_ticks - 32'd1;
          if (frac == 8'd0) begin
            frac        <= FRAC_MAX;
            encoderincm <= encoderincm - 32'd1;
          end else begin
            frac <= frac - 8'd1;
          end
        end else if (step_bad) begin
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_distance_counter.sv
// Self-checking bench for encoder_distance_counter: a scoreboard queue holds
// the expected {dir, ticks, cm} of every driven step, popped on each tick_pulse.
module tb_encoder_distance_counter;

  localparam int TPC = 12;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        enc_a;
  logic        enc_b;
  logic        encoder_reset;
  logic [31:0] encoderincm;
  logic [31:0] enc_ticks;
  logic        tick_pulse;
  logic        tick_dir;
  logic [7:0]  err_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          last_pulse_cyc = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  longint      model_t = 0;
  int          model_err = 0;
  logic [1:0]  ab_cur = 2'b00;

  encoder_distance_counter #(
    .TICKS_PER_CM(TPC),
    .FILTER_LEN(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .encoder_reset(encoder_reset),
    .encoderincm(encoderincm),
    .enc_ticks(enc_ticks),
    .tick_pulse(tick_pulse),
    .tick_dir(tick_dir),
    .err_count(err_count)
  );

  // Clock and cycle counter.
  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] floor_cm(input longint t);
    if (t >= 0) return 32'(t / TPC);
    return 32'(-((-t + TPC - 1) / TPC));
  endfunction

  // Scoreboard monitor: sample on the falling edge.
  always @(negedge clk_clk) begin
    if (tick_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      check("tick_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_tick_dir", {31'd0, tick_dir}, {31'd0, mon_e[64]});
        check("sb_enc_ticks", enc_ticks, mon_e[63:32]);
        check("sb_encoderincm", encoderincm, mon_e[31:0]);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ab);
    enc_a  = ab[1];
    enc_b  = ab[0];
    ab_cur = ab;
  endtask

  function automatic logic [1:0] next_ab(input logic [1:0] ab, input bit fwd);
    case (ab)
      2'b00:   return fwd ? 2'b01 : 2'b10;
      2'b01:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b10 : 2'b01;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  // One legal quadrature step; expected result queued when driven.
  task automatic step(input bit fwd, input int hold);
    drive(next_ab(ab_cur, fwd));
    model_t = fwd ? model_t + 1 : model_t - 1;
    exp_q.push_back({fwd, 32'(model_t), floor_cm(model_t)});
    wait_cycles(hold);
  endtask

  task automatic check_state();
    check("enc_ticks", enc_ticks, 32'(model_t));
    check("encoderincm", encoderincm, floor_cm(model_t));
    check("err_count", {24'd0, err_count}, 32'(model_err));
    check("sb_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Clear with pins moved to a new level while clear is held.
  task automatic do_clear(input logic [1:0] pins);
    encoder_reset = 1'b1;
    drive(pins);
    wait_cycles(12);
    check("clear_pulse", {31'd0, tick_pulse}, 32'd0);
    encoder_reset = 1'b0;
    model_t   = 0;
    model_err = 0;
    wait_cycles(10);
  endtask

  initial begin
    int pc0;
    int k_cyc;

    // 1: reset with pins at 11, then release
    reset_reset   = 1'b1;
    encoder_reset = 1'b0;
    drive(2'b11);
    wait_cycles(3);
    check("rst_cm", encoderincm, 32'd0);
    check("rst_ticks", enc_ticks, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    check("rst_pulse", {31'd0, tick_pulse}, 32'd0);
    check("rst_dir", {31'd0, tick_dir}, 32'd0);
    reset_reset = 1'b0;
    pc0 = pulse_cnt;
    wait_cycles(20);
    check_state();
    check("arm_no_pulse", 32'(pulse_cnt - pc0), 32'd0);

    // 2: forward counting across centimetre boundaries
    repeat (24) step(1'b1, 10);
    check("fwd24_ticks", enc_ticks, 32'd24);
    check("fwd24_cm", encoderincm, 32'd2);
    repeat (11) step(1'b1, 10);
    check("fwd35_ticks", enc_ticks, 32'd35);
    check("fwd35_cm", encoderincm, 32'd2);
    step(1'b1, 10);
    check("fwd36_ticks", enc_ticks, 32'd36);
    check("fwd36_cm", encoderincm, 32'd3);
    check("fwd_dir", {31'd0, tick_dir}, 32'd1);

    // random walk with hold times at or above the filter limit
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(6, 12));
    end
    wait_cycles(6);
    check_state();

    // 3: reverse step below zero and back
    do_clear(2'b00);
    check_state();
    step(1'b0, 10);
    check("rev_ticks", enc_ticks, 32'hFFFF_FFFF);
    check("rev_cm", encoderincm, 32'hFFFF_FFFF);
    check("rev_dir", {31'd0, tick_dir}, 32'd0);
    step(1'b1, 10);
    check("back_ticks", enc_ticks, 32'd0);
    check("back_cm", encoderincm, 32'd0);
    check("back_dir", {31'd0, tick_dir}, 32'd1);

    // 4: glitch rejection (3 cycles) and acceptance (4 cycles)
    pc0 = pulse_cnt;
    enc_a = 1'b1;
    wait_cycles(3);
    enc_a = 1'b0;
    wait_cycles(15);
    check("glitch3_pulses", 32'(pulse_cnt - pc0), 32'd0);
    pc0 = pulse_cnt;
    enc_a = 1'b1;
    model_t = model_t - 1;
    exp_q.push_back({1'b0, 32'(model_t), floor_cm(model_t)});
    @(posedge clk_clk);
    #1;
    k_cyc = cyc;
    wait_cycles(3);
    enc_a = 1'b0;
    model_t = model_t + 1;
    exp_q.push_back({1'b1, 32'(model_t), floor_cm(model_t)});
    wait_cycles(3);
    @(negedge clk_clk);
    #1;
    check("glitch4_first", 32'(pulse_cnt - pc0), 32'd1);
    check("glitch4_latency", 32'(last_pulse_cyc - k_cyc), 32'd6);
    wait_cycles(12);
    check("glitch4_pulses", 32'(pulse_cnt - pc0), 32'd2);
    check_state();

    // 5: illegal two-bit transitions, saturating error count
    pc0 = pulse_cnt;
    drive(2'b11);
    wait_cycles(10);
    model_err = 1;
    check_state();
    for (int i = 1; i < 300; i++) begin
      drive(ab_cur ^ 2'b11);
      wait_cycles(7);
      model_err = (model_err < 255) ? model_err + 1 : 255;
    end
    wait_cycles(5);
    check_state();
    check("err_sat", {24'd0, err_count}, 32'd255);
    check("illegal_pulses", 32'(pulse_cnt - pc0), 32'd0);

    // 6: clear coincident with the tick that would make cm = 5
    do_clear(2'b00);
    repeat (59) step(1'b1, 10);
    check_state();
    drive(next_ab(ab_cur, 1'b1));
    wait_cycles(6);
    encoder_reset = 1'b1;
    wait_cycles(1);
    model_t = 0;
    model_err = 0;
    check("clr_win_ticks", enc_ticks, 32'd0);
    check("clr_win_cm", encoderincm, 32'd0);
    check("clr_win_err", {24'd0, err_count}, 32'd0);
    check("clr_win_pulse", {31'd0, tick_pulse}, 32'd0);
    drive(2'b10);
    wait_cycles(20);
    encoder_reset = 1'b0;
    pc0 = pulse_cnt;
    wait_cycles(20);
    check("clr_rel_pulses", 32'(pulse_cnt - pc0), 32'd0);
    check_state();
    step(1'b1, 10);
    check("clr_step_ticks", enc_ticks, 32'd1);

    // reset in the middle of operation
    repeat (3) step(1'b1, 10);
    reset_reset = 1'b1;
    wait_cycles(1);
    check("mid_rst_ticks", enc_ticks, 32'd0);
    check("mid_rst_cm", encoderincm, 32'd0);
    check("mid_rst_dir", {31'd0, tick_dir}, 32'd0);
    check("mid_rst_pulse", {31'd0, tick_pulse}, 32'd0);
    reset_reset = 1'b0;
    model_t = 0;
    model_err = 0;
    pc0 = pulse_cnt;
    wait_cycles(20);
    check("mid_rst_arm", 32'(pulse_cnt - pc0), 32'd0);
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
